// File: rtl/div_scheduler.sv
// Two-requester front end for one shared 8-bit divider: round-robin accept, launch, wait with timeout, respond.
// Latency: 1 cycle accept-to-response for b==0, otherwise divider time + 3; requests and responses stall on valid/ready.
module div_scheduler #(
  parameter int TIMEOUT = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_q,
  output logic [7:0] rsp_r,
  output logic       rsp_dbz,
  output logic       rsp_err,
  input  logic       rsp_ready,
  output logic [7:0] div_a,
  output logic [7:0] div_b,
  output logic       div_start,
  input  logic       div_done,
  input  logic [7:0] div_q,
  input  logic [7:0] div_r
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          last_id_q, last_id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          id_q, id_d;
  logic [7:0]    quot_q, quot_d;
  logic [7:0]    rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic          err_q, err_d;
  logic [7:0]    div_a_q, div_a_d;
  logic [7:0]    div_b_q, div_b_d;
  logic          start_q, start_d;

  logic       win0, win1, idle;
  logic [7:0] sel_a, sel_b;

  // On a tie the requester that was not served last wins.
  assign win1  = req1_valid & (~req0_valid | ~last_id_q);
  assign win0  = req0_valid & ~win1;
  assign idle  = (state_q == S_IDLE) & ~reset;
  assign req0_ready = idle & win0;
  assign req1_ready = idle & win1;
  assign sel_a = win1 ? req1_a : req0_a;
  assign sel_b = win1 ? req1_b : req0_b;

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_q     = quot_q;
  assign rsp_r     = rem_q;
  assign rsp_dbz   = dbz_q;
  assign rsp_err   = err_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign div_start = start_q;

  always_comb begin
    state_d   = state_q;
    last_id_d = last_id_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    err_d     = err_q;
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    start_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          id_d = req1_ready;
          if (sel_b == 8'd0) begin
            quot_d  = 8'hFF;
            rem_d   = sel_a;
            dbz_d   = 1'b1;
            err_d   = 1'b0;
            state_d = S_RESP;
          end else begin
            div_a_d = sel_a;
            div_b_d = sel_b;
            start_d = 1'b1;
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // done in the first WAIT cycle may still belong to the previous operation
        if (cnt_q != '0 && div_done) begin
          quot_d  = div_q;
          rem_d   = div_r;
          dbz_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          quot_d  = 8'd0;
          rem_d   = 8'd0;
          dbz_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          last_id_d = id_q;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      last_id_q <= 1'b1;
      cnt_q     <= '0;
      id_q      <= 1'b0;
      quot_q    <= 8'd0;
      rem_q     <= 8'd0;
      dbz_q     <= 1'b0;
      err_q     <= 1'b0;
      div_a_q   <= 8'd0;
      div_b_q   <= 8'd0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_id_q <= last_id_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
      err_q     <= err_d;
      div_a_q   <= div_a_d;
      div_b_q   <= div_b_d;
      start_q   <= start_d;
    end
  end

endmodule

// File: tb/tb_div_scheduler.sv
// Randomised bench for div_scheduler: queued requesters, a behavioural divider and a scoreboard monitor.
// Expected responses come from plain arithmetic on the accepted operands plus the arbitration rule.
module tb_div_scheduler;

  localparam int TIMEOUT = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_id, rsp_dbz, rsp_err;
  logic [7:0] rsp_q, rsp_r;
  logic       rsp_ready = 1'b1;
  logic [7:0] div_a, div_b;
  logic       div_start;
  logic       div_done = 1'b0;
  logic [7:0] div_q = 8'd0, div_r = 8'd0;

  div_scheduler #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r),
    .rsp_dbz(rsp_dbz), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .div_a(div_a), .div_b(div_b), .div_start(div_start),
    .div_done(div_done), .div_q(div_q), .div_r(div_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  typedef struct {
    logic       id;
    logic [7:0] a, b, q, r;
    logic       dbz, err;
    int         nstart;
    int         lat;
  } exp_t;

  op_t  q0[$], q1[$];
  exp_t sb[$];
  exp_t cur;
  int   checks = 0, errors = 0;
  bit   hang = 0, rnd_ready = 0, outstanding = 0, lat_pending = 0, hold_prev = 0;
  int   stall = 0, ref_last = 1, start_cnt = 0, acc_cyc = 0, cyc = 0;
  logic [18:0] held;

  // Divider: done drops on start, rises 9 cycles after start falls; never rises while hang is set.
  int dcnt = 0;
  bit dbusy = 0;
  always @(posedge clk) begin
    if (div_start) begin
      div_done <= 1'b0;
      dcnt     <= 0;
      dbusy    <= 1'b1;
    end else if (dbusy && !hang) begin
      if (dcnt == 8) begin
        div_done <= 1'b1;
        dbusy    <= 1'b0;
        div_q    <= div_a / div_b;
        div_r    <= div_a % div_b;
      end else begin
        dcnt <= dcnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_resp(input logic id, input op_t o, input bit h);
    exp_t e;
    e.id = id; e.a = o.a; e.b = o.b;
    e.dbz = 1'b0; e.err = 1'b0; e.nstart = 1;
    if (o.b == 8'd0) begin
      e.q = 8'hFF; e.r = o.a; e.dbz = 1'b1; e.nstart = 0; e.lat = 1;
    end else if (h) begin
      e.q = 8'd0; e.r = 8'd0; e.err = 1'b1; e.lat = TIMEOUT + 2;
    end else begin
      e.q = o.a / o.b; e.r = o.a % o.b; e.lat = 12;
    end
    return e;
  endfunction

  task automatic push(input int r, input int a, input int b);
    op_t o;
    o.a = 8'(a);
    o.b = 8'(b);
    if (r == 0) q0.push_back(o); else q1.push_back(o);
  endtask

  // Requester / consumer driver
  initial begin
    logic a0, a1, rv;
    op_t  tmp;
    forever begin
      @(negedge clk);
      a0 = req0_valid & req0_ready;
      a1 = req1_valid & req1_ready;
      rv = rsp_valid;
      @(posedge clk);
      #1;
      if (a0 && q0.size() > 0) tmp = q0.pop_front();
      if (a1 && q1.size() > 0) tmp = q1.pop_front();
      if (rv && stall > 0) stall--;
      req0_valid = (q0.size() > 0);
      if (q0.size() > 0) begin req0_a = q0[0].a; req0_b = q0[0].b; end
      req1_valid = (q1.size() > 0);
      if (q1.size() > 0) begin req1_a = q1[0].a; req1_b = q1[0].b; end
      rsp_ready = (stall > 0) ? 1'b0 : (rnd_ready ? 1'($urandom % 2) : 1'b1);
    end
  end

  // Monitor / scoreboard
  initial begin
    logic w;
    op_t  o;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cyc++;
        if (req0_ready || req1_ready) begin
          chk("ready_while_busy", 64'(outstanding), 64'd0);
          chk("ready_no_valid", 64'({req0_ready & ~req0_valid, req1_ready & ~req1_valid}), 64'd0);
          chk("both_ready", 64'(req0_ready & req1_ready), 64'd0);
          w = (req0_valid && req1_valid) ? (ref_last == 1 ? 1'b0 : 1'b1) : req1_valid;
          chk("arb_winner", 64'(req1_ready), 64'(w));
          o.a = w ? req1_a : req0_a;
          o.b = w ? req1_b : req0_b;
          cur = ref_resp(w, o, hang);
          sb.push_back(cur);
          outstanding = 1; start_cnt = 0; acc_cyc = cyc; lat_pending = 1;
        end
        if (div_start) begin
          start_cnt++;
          chk("start_when_busy", 64'(outstanding), 64'd1);
          chk("div_operands", 64'({div_a, div_b}), 64'({cur.a, cur.b}));
        end
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
          end else begin
            if (lat_pending) begin
              chk("rsp_latency", 64'(cyc - acc_cyc), 64'(sb[0].lat));
              lat_pending = 0;
            end
            if (hold_prev) chk("rsp_stable", 64'({rsp_id, rsp_q, rsp_r, rsp_dbz, rsp_err}), 64'(held));
            if (rsp_ready) begin
              e = sb.pop_front();
              chk("rsp_id", 64'(rsp_id), 64'(e.id));
              chk("rsp_q", 64'(rsp_q), 64'(e.q));
              chk("rsp_r", 64'(rsp_r), 64'(e.r));
              chk("rsp_flags", 64'({rsp_dbz, rsp_err}), 64'({e.dbz, e.err}));
              chk("start_count", 64'(start_cnt), 64'(e.nstart));
              ref_last = int'(e.id);
              outstanding = 0; hold_prev = 0;
            end else begin
              hold_prev = 1;
              held = {rsp_id, rsp_q, rsp_r, rsp_dbz, rsp_err};
            end
          end
        end
      end
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0 || outstanding) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 64'(q0.size() + q1.size() + sb.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [38:0] all_outs();
    return {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz, rsp_err,
            div_a, div_b, div_start};
  endfunction

  initial begin
    int n;
    #2 reset = 1'b1;
    #1 chk("reset_outputs", 64'(all_outs()), 64'd0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;

    // single request, tie pair, tie again, divide by zero
    @(negedge clk); push(0, 100, 7); drain(200);
    @(negedge clk); push(0, 20, 3); push(1, 200, 9); drain(200);
    @(negedge clk); push(0, 9, 4); push(1, 250, 16); drain(200);
    @(negedge clk); push(1, 55, 0); drain(200);

    // divider never completes, then a normal request
    hang = 1;
    @(negedge clk); push(0, 50, 5); drain(200);
    hang = 0;
    @(negedge clk); push(1, 77, 8); drain(200);

    // consumer stalls five cycles in RESP while another requester waits
    stall = 5;
    @(negedge clk); push(0, 33, 4); push(1, 90, 10); drain(300);

    // reset in the middle of WAIT with a request pending
    @(negedge clk); push(0, 200, 3);
    n = 0;
    while (!div_start && n < 20) begin @(negedge clk); n++; end
    chk("start_seen", 64'(div_start), 64'd1);
    push(1, 11, 2);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1 chk("reset_mid_wait", 64'(all_outs()), 64'd0);
    q0.delete(); q1.delete(); sb.delete();
    req0_valid = 1'b0; req1_valid = 1'b0;
    outstanding = 0; lat_pending = 0; hold_prev = 0; stall = 0; ref_last = 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    push(0, 60, 7); push(1, 61, 8); drain(200);

    // randomised traffic with random consumer backpressure
    rnd_ready = 1;
    for (int i = 0; i < 60; i++) begin
      push(int'($urandom % 2), int'($urandom % 256),
           ($urandom % 6 == 0) ? 0 : int'($urandom_range(1, 255)));
      repeat ($urandom % 12) @(negedge clk);
    end
    drain(5000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
